voice_allocator: RTL

- Parametrised polyphonic voice allocator for the wavetable synth path. Maps up to NUM_NOTES gated notes onto NUM_VOICES persistent voice slots.
- Assignments are stable across cycles; a voice is not recomputed from scratch every clock.
- Configurable voice stealing when all voices are busy.
- Emits one registered wavetable address per voice, taken from that voice's note phase, for the downstream per-voice table readers and mixer.

---
 rtl/synth_pkg.sv | 17 +
 rtl/voice_select.sv | 38 +++
 rtl/voice_allocator.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared defaults and types for the synth voice path
package synth_pkg;

  localparam int SYNTH_NUM_NOTES      = 24;
  localparam int SYNTH_NUM_VOICES     = 8;
  localparam int SYNTH_NOTE_IDX_WIDTH = $clog2(SYNTH_NUM_NOTES);
  localparam int SYNTH_AGE_WIDTH      = 16;

  typedef logic [SYNTH_NOTE_IDX_WIDTH-1:0] note_idx_t;

  typedef struct packed {
    logic                       valid;
    note_idx_t                  note;
    logic [SYNTH_AGE_WIDTH-1:0] age;
  } voice_slot_t;

endpackage

// File: rtl/voice_select.sv
// rtl/voice_select.sv - lowest free voice and oldest voice selection
module voice_select
  import synth_pkg::*;
#(
  parameter int NUM_VOICES      = SYNTH_NUM_VOICES,
  parameter int AGE_WIDTH       = SYNTH_AGE_WIDTH,
  parameter int VOICE_IDX_WIDTH = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic [NUM_VOICES-1:0]                valid,
  input  logic [NUM_VOICES-1:0][AGE_WIDTH-1:0] age,
  output logic                                 free_found,
  output logic [VOICE_IDX_WIDTH-1:0]           free_idx,
  output logic [VOICE_IDX_WIDTH-1:0]           oldest_idx
);

  logic [AGE_WIDTH-1:0] max_age;

  // Descending scan leaves the lowest free index; strict compare keeps the lowest index on age ties.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!valid[v]) begin
        free_found = 1'b1;
        free_idx   = VOICE_IDX_WIDTH'(v);
      end
    end
    oldest_idx = '0;
    max_age    = age[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age[v] > max_age) begin
        max_age    = age[v];
        oldest_idx = VOICE_IDX_WIDTH'(v);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - scanning polyphonic voice allocator with stealing
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_NOTES      = SYNTH_NUM_NOTES,
  parameter int NUM_VOICES     = SYNTH_NUM_VOICES,
  parameter int PHASE_WIDTH    = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int NOTE_IDX_WIDTH = $clog2(NUM_NOTES),
  parameter int AGE_WIDTH      = SYNTH_AGE_WIDTH,
  parameter bit STEAL_EN       = 1'b1
) (
  input  logic                                        clk_in,
  input  logic                                        rst_n_in,
  input  logic [NUM_NOTES-1:0][PHASE_WIDTH-1:0]       phase_in,
  input  logic [NUM_NOTES-1:0]                        gate_in,
  output logic [NUM_VOICES-1:0]                       voice_valid_out,
  output logic [NUM_VOICES-1:0][NOTE_IDX_WIDTH-1:0]   voice_note_out,
  output logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0]       voice_addr_out,
  output logic [NUM_NOTES-1:0]                        note_active_out,
  output logic [$clog2(NUM_VOICES+1)-1:0]             num_voices_out,
  output logic                                        alloc_pulse_out,
  output logic                                        steal_pulse_out,
  output logic                                        drop_pulse_out
);

  localparam int VOICE_IDX_WIDTH = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_WIDTH       = $clog2(NUM_VOICES + 1);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = {AGE_WIDTH{1'b1}};

  logic [NOTE_IDX_WIDTH-1:0]                      scan_ptr;
  logic [NUM_NOTES-1:0]                           gate_seen;
  logic [NUM_VOICES-1:0]                          voice_valid;
  logic [NUM_VOICES-1:0][NOTE_IDX_WIDTH-1:0]      voice_note;
  logic [NUM_VOICES-1:0][AGE_WIDTH-1:0]           voice_age;
  logic [NUM_NOTES-1:0]                           note_active;
  logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0]          voice_addr;
  logic [CNT_WIDTH-1:0]                           num_voices;
  logic                                           alloc_pulse;
  logic                                           steal_pulse;
  logic                                           drop_pulse;

  logic                                           free_found;
  logic [VOICE_IDX_WIDTH-1:0]                     free_idx;
  logic [VOICE_IDX_WIDTH-1:0]                     oldest_idx;

  logic                                           note_on;
  logic                                           note_off;
  logic                                           owner_found;
  logic [VOICE_IDX_WIDTH-1:0]                     owner_idx;
  logic [NOTE_IDX_WIDTH-1:0]                      ptr_nxt;
  logic [NUM_NOTES-1:0]                           gate_seen_nxt;
  logic [NUM_VOICES-1:0]                          valid_nxt;
  logic [NUM_VOICES-1:0][NOTE_IDX_WIDTH-1:0]      note_nxt;
  logic [NUM_VOICES-1:0][AGE_WIDTH-1:0]           age_nxt;
  logic [NUM_NOTES-1:0]                           active_nxt;
  logic [CNT_WIDTH-1:0]                           count_nxt;
  logic                                           alloc_nxt;
  logic                                           steal_nxt;
  logic                                           drop_nxt;

  voice_select #(
    .NUM_VOICES      (NUM_VOICES),
    .AGE_WIDTH       (AGE_WIDTH),
    .VOICE_IDX_WIDTH (VOICE_IDX_WIDTH)
  ) u_voice_select (
    .valid      (voice_valid),
    .age        (voice_age),
    .free_found (free_found),
    .free_idx   (free_idx),
    .oldest_idx (oldest_idx)
  );

  // Locate the voice currently owned by the scanned note (used for note-off).
  always_comb begin
    owner_found = 1'b0;
    owner_idx   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voice_valid[v] && (voice_note[v] == scan_ptr) && !owner_found) begin
        owner_found = 1'b1;
        owner_idx   = VOICE_IDX_WIDTH'(v);
      end
    end
  end

  // Next-state for the scanned note: note-on (alloc/steal/drop) beats note-off; ages tick every cycle.
  always_comb begin
    note_on       = gate_in[scan_ptr] & ~gate_seen[scan_ptr];
    note_off      = ~gate_in[scan_ptr] & note_active[scan_ptr];
    ptr_nxt       = (scan_ptr == NOTE_IDX_WIDTH'(NUM_NOTES - 1)) ? '0 : scan_ptr + 1'b1;
    gate_seen_nxt = gate_seen;
    gate_seen_nxt[scan_ptr] = gate_in[scan_ptr];
    valid_nxt     = voice_valid;
    note_nxt      = voice_note;
    active_nxt    = note_active;
    alloc_nxt     = 1'b0;
    steal_nxt     = 1'b0;
    drop_nxt      = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!voice_valid[v]) begin
        age_nxt[v] = '0;
      end else if (voice_age[v] == AGE_MAX) begin
        age_nxt[v] = voice_age[v];
      end else begin
        age_nxt[v] = voice_age[v] + 1'b1;
      end
    end
    if (note_on) begin
      if (free_found) begin
        valid_nxt[free_idx] = 1'b1;
        note_nxt[free_idx]  = scan_ptr;
        age_nxt[free_idx]   = '0;
        active_nxt[scan_ptr] = 1'b1;
        alloc_nxt = 1'b1;
      end else if (STEAL_EN) begin
        // The previous owner keeps its gate_seen bit, so it stays silent until re-gated.
        active_nxt[voice_note[oldest_idx]] = 1'b0;
        note_nxt[oldest_idx] = scan_ptr;
        age_nxt[oldest_idx]  = '0;
        active_nxt[scan_ptr] = 1'b1;
        alloc_nxt = 1'b1;
        steal_nxt = 1'b1;
      end else begin
        drop_nxt = 1'b1;
      end
    end else if (note_off) begin
      if (owner_found) begin
        valid_nxt[owner_idx] = 1'b0;
        age_nxt[owner_idx]   = '0;
      end
      active_nxt[scan_ptr] = 1'b0;
    end
    count_nxt = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      count_nxt = count_nxt + CNT_WIDTH'(valid_nxt[v]);
    end
  end

  // Scan pointer, gate history, voice slots, occupancy count and event pulses.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      scan_ptr    <= '0;
      gate_seen   <= '0;
      voice_valid <= '0;
      voice_note  <= '0;
      voice_age   <= '0;
      note_active <= '0;
      num_voices  <= '0;
      alloc_pulse <= 1'b0;
      steal_pulse <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      scan_ptr    <= ptr_nxt;
      gate_seen   <= gate_seen_nxt;
      voice_valid <= valid_nxt;
      voice_note  <= note_nxt;
      voice_age   <= age_nxt;
      note_active <= active_nxt;
      num_voices  <= count_nxt;
      alloc_pulse <= alloc_nxt;
      steal_pulse <= steal_nxt;
      drop_pulse  <= drop_nxt;
    end
  end

  // Per-voice wavetable address: top bits of the owning note's phase, zero when the voice is idle.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      voice_addr <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        voice_addr[v] <= voice_valid[v] ? phase_in[voice_note[v]][PHASE_WIDTH-1 -: ADDR_WIDTH] : '0;
      end
    end
  end

  assign voice_valid_out = voice_valid;
  assign voice_note_out  = voice_note;
  assign voice_addr_out  = voice_addr;
  assign note_active_out = note_active;
  assign num_voices_out  = num_voices;
  assign alloc_pulse_out = alloc_pulse;
  assign steal_pulse_out = steal_pulse;
  assign drop_pulse_out  = drop_pulse;

endmodule
